ultrasonic_ranger: RTL and testbench

// - Drives an HC-SR04-style ultrasound sensor and converts its echo pulse width into whole centimetres.
// - Works in the opposite direction to the board clock divider: that block turns a cycle count into a

---
 rtl/ultrasonic_ranger_pkg.sv | 20 ++
 rtl/ultrasonic_ranger_echo_sync.sv | 30 +++
 rtl/ultrasonic_ranger.sv | 153 +++++++++++++++
 tb/tb_ultrasonic_ranger.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ultrasonic_ranger_pkg.sv
// Shared FSM encoding and default 50 MHz timing constants for the ultrasonic ranger.
package ultrasonic_ranger_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    HOLDOFF   = 3'd4
  } state_t;

  localparam int unsigned CYCLES_PER_CM_DEF = 2900;     // 58 us of echo per cm
  localparam int unsigned TRIG_CYCLES_DEF   = 500;      // 10 us trigger
  localparam int unsigned RISE_TIMEOUT_DEF  = 1500000;  // 30 ms without an echo
  localparam int unsigned MAX_CM_DEF        = 400;
  localparam int unsigned PERIOD_CYCLES_DEF = 3000000;  // 60 ms between triggers

  localparam int unsigned DIST_W = 9;

endpackage

// File: rtl/ultrasonic_ranger_echo_sync.sv
// Two-flop synchronizer for the raw echo pin plus rise/fall detection on the synchronized level.
// Rise and fall see the same 2-cycle delay, so pulse width is preserved.
module echo_sync (
  input  logic clk,
  input  logic rst,
  input  logic echo,
  output logic echo_s,
  output logic echo_rise,
  output logic echo_fall
);

  logic echo_meta;
  logic echo_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      echo_meta <= 1'b0;
      echo_s    <= 1'b0;
      echo_d    <= 1'b0;
    end else begin
      echo_meta <= echo;
      echo_s    <= echo_meta;
      echo_d    <= echo_s;
    end
  end

  assign echo_rise = echo_s & ~echo_d;
  assign echo_fall = ~echo_s & echo_d;

endmodule

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 style ranger: fires trig, times the echo pulse and reports whole centimetres,
// with a no-echo timeout, saturation at MAX_CM and a minimum trigger period.
module ultrasonic_ranger
  import ultrasonic_ranger_pkg::*;
#(
  parameter int unsigned CYCLES_PER_CM = CYCLES_PER_CM_DEF,
  parameter int unsigned TRIG_CYCLES   = TRIG_CYCLES_DEF,
  parameter int unsigned RISE_TIMEOUT  = RISE_TIMEOUT_DEF,
  parameter int unsigned MAX_CM        = MAX_CM_DEF,
  parameter int unsigned PERIOD_CYCLES = PERIOD_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              echo,
  output logic              trig,
  output logic              busy,
  output logic [DIST_W-1:0] dist_cm,
  output logic              valid,
  output logic              timeout
);

  localparam int PRE_W  = $clog2(CYCLES_PER_CM + 1);
  localparam int TRIG_W = $clog2(TRIG_CYCLES + 1);
  localparam int RISE_W = $clog2(RISE_TIMEOUT + 1);
  localparam int CM_W   = $clog2(MAX_CM + 1);
  localparam int PER_W  = $clog2(PERIOD_CYCLES + 1);

  state_t            state;
  logic [PRE_W-1:0]  pre_cnt;
  logic [CM_W-1:0]   cm_cnt;
  logic [TRIG_W-1:0] trig_cnt;
  logic [RISE_W-1:0] wait_cnt;
  logic [PER_W-1:0]  per_cnt;

  logic echo_s;
  logic echo_rise;
  logic echo_fall;
  logic echo_hi_d;
  logic wrap;
  logic [CM_W-1:0] cm_next;

  echo_sync u_echo_sync (
    .clk       (clk),
    .rst       (rst),
    .echo      (echo),
    .echo_s    (echo_s),
    .echo_rise (echo_rise),
    .echo_fall (echo_fall)
  );

  // Count on the one-cycle-delayed level: it is high on exactly N MEASURE cycles for
  // an N-cycle pulse, including the cycle the fall is seen, so a wrap on that cycle
  // still lands in the result.
  always_comb begin
    echo_hi_d = (echo_s & ~echo_rise) | echo_fall;
    wrap      = echo_hi_d && (pre_cnt == PRE_W'(CYCLES_PER_CM - 1));
    cm_next   = cm_cnt;
    if (wrap && (cm_cnt != CM_W'(MAX_CM))) begin
      cm_next = cm_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      trig     <= 1'b0;
      busy     <= 1'b0;
      dist_cm  <= '0;
      valid    <= 1'b0;
      timeout  <= 1'b0;
      pre_cnt  <= '0;
      cm_cnt   <= '0;
      trig_cnt <= '0;
      wait_cnt <= '0;
      per_cnt  <= '0;
    end else begin
      valid <= 1'b0;
      if ((state != IDLE) && (per_cnt != PER_W'(PERIOD_CYCLES))) begin
        per_cnt <= per_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state    <= TRIG;
            trig     <= 1'b1;
            busy     <= 1'b1;
            per_cnt  <= '0;
            trig_cnt <= '0;
          end
        end

        TRIG: begin
          if (trig_cnt == TRIG_W'(TRIG_CYCLES - 1)) begin
            trig     <= 1'b0;
            state    <= WAIT_RISE;
            wait_cnt <= '0;
          end else begin
            trig_cnt <= trig_cnt + 1'b1;
          end
        end

        WAIT_RISE: begin
          if (echo_rise) begin
            state   <= MEASURE;
            pre_cnt <= '0;
            cm_cnt  <= '0;
          end else if (wait_cnt == RISE_W'(RISE_TIMEOUT - 1)) begin
            valid   <= 1'b1;
            timeout <= 1'b1;
            dist_cm <= DIST_W'(MAX_CM);
            state   <= HOLDOFF;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        MEASURE: begin
          if (echo_hi_d) begin
            pre_cnt <= wrap ? '0 : pre_cnt + 1'b1;
          end
          cm_cnt <= cm_next;
          if (cm_next == CM_W'(MAX_CM)) begin
            valid   <= 1'b1;
            timeout <= 1'b1;
            dist_cm <= DIST_W'(MAX_CM);
            state   <= HOLDOFF;
          end else if (echo_fall) begin
            valid   <= 1'b1;
            timeout <= 1'b0;
            dist_cm <= DIST_W'(cm_next);
            state   <= HOLDOFF;
          end
        end

        HOLDOFF: begin
          if (per_cnt >= PER_W'(PERIOD_CYCLES - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          trig  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for ultrasonic_ranger with scaled-down timing constants.
module tb_ultrasonic_ranger;

  localparam int CPC = 10;
  localparam int TC  = 5;
  localparam int RT  = 300;
  localparam int MC  = 400;
  localparam int PC  = 4100;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       echo;
  logic       trig;
  logic       busy;
  logic [8:0] dist_cm;
  logic       valid;
  logic       timeout;

  int errors    = 0;
  int checks    = 0;
  int valid_cnt = 0;

  always #5 clk = ~clk;

  ultrasonic_ranger #(
    .CYCLES_PER_CM (CPC),
    .TRIG_CYCLES   (TC),
    .RISE_TIMEOUT  (RT),
    .MAX_CM        (MC),
    .PERIOD_CYCLES (PC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .echo    (echo),
    .trig    (trig),
    .busy    (busy),
    .dist_cm (dist_cm),
    .valid   (valid),
    .timeout (timeout)
  );

  always @(negedge clk) if (valid === 1'b1) valid_cnt++;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic start_pulse();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_trig_fall(input string name);
    bit done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (trig === 1'b0) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_trig_fall: trig still %b after 100 cycles, expected 0", name, trig);
    end
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int i = 0; i < PC + 200 && !done; i++) begin
      @(negedge clk);
      if (busy === 1'b0) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_idle: busy still %b after %0d cycles, expected 0", name, busy, PC + 200);
    end
  endtask

  task automatic wait_valid(input int budget, output bit got, output int cycles);
    got = 0;
    cycles = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      cycles++;
      if (valid === 1'b1) got = 1;
    end
  endtask

  task automatic measure(input int n, input logic [8:0] exp_d, input bit poke, input string name);
    int v0;
    int trig_seen;
    int cyc;
    bit got;
    v0 = valid_cnt;
    start_pulse();
    wait_trig_fall(name);
    if (poke) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      trig_seen = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (trig === 1'b1) trig_seen++;
      end
      checks++;
      if (trig_seen != 0) begin
        errors++;
        $display("FAIL %s_start_ignored: trig high %0d cycles, expected 0", name, trig_seen);
      end
    end
    repeat (3) @(negedge clk);
    echo = 1'b1;
    repeat (n) @(negedge clk);
    echo = 1'b0;
    wait_valid(40, got, cyc);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_valid: no valid within 40 cycles of echo fall, expected one", name);
    end else begin
      checks++;
      if (dist_cm !== exp_d) begin
        errors++;
        $display("FAIL %s_dist: dist_cm=%0d, expected %0d", name, dist_cm, exp_d);
      end
      checks++;
      if (timeout !== 1'b0) begin
        errors++;
        $display("FAIL %s_timeout: timeout=%b, expected 0", name, timeout);
      end
    end
    wait_idle(name);
    checks++;
    if (valid_cnt - v0 != 1) begin
      errors++;
      $display("FAIL %s_valid_count: %0d valid pulses, expected 1", name, valid_cnt - v0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; echo = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({trig, busy, valid, timeout} !== 4'b0000 || dist_cm !== 9'd0) begin
      errors++;
      $display("FAIL reset_state: trig=%b busy=%b valid=%b timeout=%b dist=%0d, expected all 0",
               trig, busy, valid, timeout, dist_cm);
    end
    start_pulse();
    @(negedge clk);
    checks++;
    if (trig !== 1'b1) begin
      errors++;
      $display("FAIL reset_trig_on: trig=%b before reset, expected 1", trig);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (trig !== 1'b0 || busy !== 1'b0 || dist_cm !== 9'd0) begin
      errors++;
      $display("FAIL reset_async: trig=%b busy=%b dist=%0d mid-cycle, expected 0 0 0", trig, busy, dist_cm);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (trig !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_released: trig=%b busy=%b, expected 0 0", trig, busy);
    end
    measure(50, 9'd5, 1'b0, "after_reset");
  endtask

  task automatic test_nominal();
    measure(200, 9'd20, 1'b1, "nominal");
  endtask

  task automatic test_boundary();
    measure(199, 9'd19, 1'b0, "b199");
    measure(10,  9'd1,  1'b0, "b10");
    measure(9,   9'd0,  1'b0, "b9");
  endtask

  task automatic test_no_echo();
    int j;
    bit got;
    echo = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_valid(RT + TC + 50, got, j);
    checks++;
    if (!got || j < TC + RT - 2 || j > TC + RT + 2) begin
      errors++;
      $display("FAIL no_echo_latency: valid after %0d cycles (seen=%b), expected %0d +/-2", j, got, TC + RT);
    end
    checks++;
    if (dist_cm !== 9'd400 || timeout !== 1'b1) begin
      errors++;
      $display("FAIL no_echo_result: dist=%0d timeout=%b, expected 400 1", dist_cm, timeout);
    end
    wait_idle("no_echo");
  endtask

  task automatic test_saturation();
    int v0;
    int cyc;
    bit got;
    v0 = valid_cnt;
    start_pulse();
    wait_trig_fall("sat");
    repeat (3) @(negedge clk);
    echo = 1'b1;
    wait_valid(MC * CPC + 50, got, cyc);
    checks++;
    if (!got || cyc < MC * CPC || cyc > MC * CPC + 6) begin
      errors++;
      $display("FAIL sat_latency: valid after %0d cycles (seen=%b), expected %0d..%0d", cyc, got, MC * CPC, MC * CPC + 6);
    end
    checks++;
    if (dist_cm !== 9'd400 || timeout !== 1'b1) begin
      errors++;
      $display("FAIL sat_result: dist=%0d timeout=%b, expected 400 1", dist_cm, timeout);
    end
    repeat (10) @(negedge clk);
    echo = 1'b0;
    wait_idle("sat");
    checks++;
    if (valid_cnt - v0 != 1) begin
      errors++;
      $display("FAIL sat_valid_count: %0d valid pulses, expected 1", valid_cnt - v0);
    end
  endtask

  task automatic test_already_high();
    int v0;
    v0 = valid_cnt;
    echo = 1'b1;
    start_pulse();
    wait_trig_fall("high");
    repeat (30) @(negedge clk);
    checks++;
    if (valid_cnt != v0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL high_no_measure: %0d valid pulses busy=%b while echo stuck high, expected 0 1",
               valid_cnt - v0, busy);
    end
    echo = 1'b0;
    repeat (5) @(negedge clk);
    echo = 1'b1;
    repeat (70) @(negedge clk);
    echo = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (valid_cnt - v0 != 1 || dist_cm !== 9'd7 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL high_remeasure: valids=%0d dist=%0d timeout=%b, expected 1 7 0",
               valid_cnt - v0, dist_cm, timeout);
    end
    wait_idle("high");
  endtask

  task automatic test_back_to_back();
    int rise_t[3];
    int width[3];
    int nrise;
    int busy_low;
    logic prev_trig;
    nrise = 0; busy_low = 0; prev_trig = 1'b0;
    for (int k = 0; k < 3; k++) begin rise_t[k] = 0; width[k] = 0; end
    echo = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int t = 0; t < 2 * (PC + 1) + PC / 2; t++) begin
      @(negedge clk);
      if (trig === 1'b1 && prev_trig === 1'b0) begin
        if (nrise < 3) rise_t[nrise] = t;
        nrise++;
      end
      if (trig === 1'b1 && nrise >= 1 && nrise <= 3) width[nrise-1]++;
      if (busy !== 1'b1 && nrise >= 1 && nrise < 3) busy_low++;
      prev_trig = trig;
    end
    start = 1'b0;
    checks++;
    if (nrise != 3) begin
      errors++;
      $display("FAIL rate_count: %0d trig rises, expected 3", nrise);
    end
    checks++;
    if (rise_t[1] - rise_t[0] != PC + 1 || rise_t[2] - rise_t[1] != PC + 1) begin
      errors++;
      $display("FAIL rate_spacing: spacing %0d and %0d, expected %0d", rise_t[1] - rise_t[0],
               rise_t[2] - rise_t[1], PC + 1);
    end
    checks++;
    if (width[0] != TC || width[1] != TC || width[2] != TC) begin
      errors++;
      $display("FAIL rate_width: widths %0d %0d %0d, expected %0d", width[0], width[1], width[2], TC);
    end
    checks++;
    if (busy_low != 2) begin
      errors++;
      $display("FAIL rate_busy_gap: busy low %0d cycles over two periods, expected 2", busy_low);
    end
    wait_idle("rate");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_boundary();
    test_no_echo();
    test_saturation();
    test_already_high();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
